// File: rtl/integration_nios2_cpu_jtag_mon_ctrl.sv
// JTAG debug monitor sequencer: turns take_* pulses into monitor memory reads/writes.
// Define MONITOR_TIMEOUT_EN to add a watchdog that abandons requests stalled too long.
module integration_nios2_cpu_jtag_mon_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] mon_a_r, mon_a_s;
  logic [31:0]       mon_d_r, mon_d_s;
  logic              ready_r, ready_s;
  logic              error_r, error_s;
  logic              read_r, write_r;
  logic              any_take_s;
  logic              timeout_s;
  logic              unused_jdo_s;

  assign any_take_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

`ifdef MONITOR_TIMEOUT_EN
  logic [7:0] wdog_r;

  // Watchdog: zero while idle so every request starts a fresh count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_r <= 8'd0;
    end else if (state_r == ST_IDLE) begin
      wdog_r <= 8'd0;
    end else begin
      wdog_r <= wdog_r + 8'd1;
    end
  end

  assign timeout_s = (state_r != ST_IDLE) && mem_waitrequest &&
                     (wdog_r == 8'(TIMEOUT_CYCLES - 1));
`else
  logic [7:0] unused_timeout_s;

  assign unused_timeout_s = 8'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  // Next-state and register-update decode
  always_comb begin
    state_s = state_r;
    mon_a_s = mon_a_r;
    mon_d_s = mon_d_r;
    ready_s = ready_r;
    error_s = error_r;
    case (state_r)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_s = ADDR_W'(jdo[25:16]);
          error_s = 1'b0;
          if (jdo[35]) begin
            state_s = ST_READ;
            ready_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
            ready_s = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          mon_d_s = jdo[34:3];
          state_s = ST_WRITE;
          ready_s = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          mon_a_s = mon_a_r + ADDR_W'(1'b1);
          state_s = ST_READ;
          ready_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ, ST_WRITE: begin
        // Commands while busy are dropped but remembered as an error
        error_s = error_r | any_take_s;
        if (!mem_waitrequest) begin
          ready_s = 1'b1;
          state_s = ST_IDLE;
          if (state_r == ST_READ) begin
            mon_d_s = mem_rdata;
          end else begin
            mon_a_s = mon_a_r + ADDR_W'(1'b1);
          end
        end else if (timeout_s) begin
          ready_s = 1'b1;
          error_s = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, monitor registers and strobes; strobes follow the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      mon_a_r <= '0;
      mon_d_r <= 32'd0;
      ready_r <= 1'b0;
      error_r <= 1'b0;
      read_r  <= 1'b0;
      write_r <= 1'b0;
    end else begin
      state_r <= state_s;
      mon_a_r <= mon_a_s;
      mon_d_r <= mon_d_s;
      ready_r <= ready_s;
      error_r <= error_s;
      read_r  <= (state_s == ST_READ);
      write_r <= (state_s == ST_WRITE);
    end
  end

  assign mem_addr      = mon_a_r;
  assign mem_wdata     = mon_d_r;
  assign MonDReg       = mon_d_r;
  assign mem_read      = read_r;
  assign mem_write     = write_r;
  assign monitor_ready = ready_r;
  assign monitor_error = error_r;

endmodule
